// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory slave with RAM, a free-running
// cycle counter and an LED register, answering each request in 3 cycles.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mem_req             access request, sampled only in IDLE
//   mem_wren            1 = write, 0 = read
//   mem_byte            1 = byte access, 0 = word access
//   mem_addr            byte address
//   mem_write_data      store data (byte stores replicate the byte)
//   mem_read_data       registered read word
//   mem_ack             one-cycle completion pulse
//   mem_err             error flag, valid with mem_ack
//   led                 LED register contents
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] CNT_ADDR    = 32'hFFFF_0000,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wren,
  input  logic        mem_byte,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ack,
  output logic        mem_err,
  output logic [31:0] led
);

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES =
    33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wren_q;
  logic        byte_q;

  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] cnt_q;
  logic [31:0] led_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          accept;
  logic          commit;
  logic          aligned;
  logic          hit_ram;
  logic          hit_cnt;
  logic          hit_led;
  logic          sel_ram;
  logic          sel_cnt;
  logic          sel_led;
  logic          acc_err;
  logic [AW-1:0] ram_idx;
  logic [3:0]    be;
  logic [31:0]   rd_word;
  logic [31:0]   led_wr;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset edge neither accepts a request nor completes one.
  assign accept = (state_q == IDLE) && mem_req && !rst;
  assign commit = (state_q == ACCESS) && !rst;

  // Request capture; later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_write_data;
      wren_q  <= mem_wren;
      byte_q  <= mem_byte;
    end
  end

  // Address decode.  RAM takes priority so the selects stay
  // mutually exclusive even if a region overlaps the MMIO words.
  assign aligned = byte_q || (addr_q[1:0] == 2'b00);
  assign hit_ram = {1'b0, addr_q} < RAM_BYTES;
  assign hit_cnt = !hit_ram &&
                   (addr_q[31:2] == CNT_ADDR[31:2]);
  assign hit_led = !hit_ram && !hit_cnt &&
                   (addr_q[31:2] == LED_ADDR[31:2]);

  assign sel_ram = aligned && hit_ram;
  assign sel_cnt = aligned && hit_cnt;
  assign sel_led = aligned && hit_led;
  assign acc_err = !(sel_ram || sel_cnt || sel_led);

  assign ram_idx = addr_q[AW+1:2];

  // Lane enables: one lane for byte stores, all four for words.
  always_comb begin
    be = 4'b0000;
    if (byte_q) begin
      be[addr_q[1:0]] = 1'b1;
    end else begin
      be = 4'b1111;
    end
  end

  // Read source; errors and unmapped addresses read as zero.
  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      sel_ram: rd_word = ram[ram_idx];
      sel_cnt: rd_word = cnt_q;
      sel_led: rd_word = led_q;
      default: rd_word = '0;
    endcase
  end

  // LED value after a lane-masked write.
  always_comb begin
    led_wr = led_q;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) begin
        led_wr[8*l +: 8] = wdata_q[8*l +: 8];
      end
    end
  end

  // RAM array: byte-lane writes, never cleared by reset.
  always_ff @(posedge clk) begin
    if (commit && wren_q && sel_ram) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          ram[ram_idx][8*l +: 8] <= wdata_q[8*l +: 8];
        end
      end
    end
  end

  // Counter, LED register and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      led_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (commit) begin
        rdata_q <= rd_word;
        err_q   <= acc_err;
        if (wren_q && sel_led) begin
          led_q <= led_wr;
        end
      end
    end
  end

  assign mem_ack       = (state_q == RESP);
  assign mem_err       = err_q;
  assign mem_read_data = rdata_q;
  assign led           = led_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words; RAM byte range 0 .. DEPTH_WORDS*4-1.
REQ-002 Parameter CNT_ADDR, default 32'hFFFF_0000, address of read-only cycle counter.
REQ-003 Parameter LED_ADDR, default 32'hFFFF_0004, address of read/write LED register.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mem_req  input  1  CPU access request, sampled only in IDLE.
REQ-007 mem_wren  input  1  1 = write, 0 = read.
REQ-008 mem_byte  input  1  1 = byte access (SB/LBU), 0 = word access (SW/LW).
REQ-009 mem_addr  input  32  byte address.
REQ-010 mem_write_data  input  32  store data; for byte stores the byte is replicated on all four lanes.
REQ-011 mem_read_data  output  32  registered read word.
REQ-012 mem_ack  output  1  one-cycle completion pulse.
REQ-013 mem_err  output  1  error status for the acknowledged access; valid only while mem_ack=1.
REQ-014 led  output  32  LED register contents.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP. IDLE->ACCESS when mem_req=1; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 On the IDLE->ACCESS edge, latch mem_addr, mem_write_data, mem_wren and mem_byte; later input changes do not affect this access.
REQ-017 mem_req outside IDLE: ignored; no queueing.
REQ-018 Perform the RAM/register operation on the ACCESS->RESP edge.
REQ-019 mem_ack=1 exactly while in RESP: accept edge N, ack high between edges N+2 and N+3.
REQ-020 mem_read_data and mem_err are updated on that same ACCESS->RESP edge and hold until the next access completes.
REQ-021 mem_req held high through RESP is re-accepted in IDLE, giving back-to-back accesses every 3 cycles.
REQ-022 Address decode:
- addr < DEPTH_WORDS*4 -> RAM.
- addr[31:2] == CNT_ADDR[31:2] -> counter.
- addr[31:2] == LED_ADDR[31:2] -> LED.
- anything else -> unmapped: mem_err=1, read data 0, no write.
REQ-023 Word access with addr[1:0]!=0: mem_err=1, read data 0, no write.
REQ-024 RAM word index = addr[31:2]; word read returns the full stored word.
REQ-025 Byte read returns the full aligned word at addr[31:2]; the requester extracts lane addr[1:0]; mem_err=0.
REQ-026 Byte write: only lane L=addr[1:0] is updated, with mem_write_data[8L+7:8L]; other three bytes unchanged. Applies to RAM and LED.
REQ-027 Word write: full 32-bit update of RAM word or LED.
REQ-028 Cycle counter: 32-bit, +1 every clock, wraps FFFF_FFFF->0. A read returns the value held on the ACCESS->RESP edge. Writes are ignored with mem_err=0.
REQ-029 led reflects the LED register combinationally from its flop; it changes on the ACCESS->RESP edge of a write.
REQ-030 mem_err=0 for every access not covered by REQ-022 (unmapped) or REQ-023 (misaligned word).

Reset
REQ-031 rst=1 at an edge:
- state -> IDLE; mem_ack=0, mem_err=0, mem_read_data=0, led=0, counter=0.
- A write pending in ACCESS is not performed; no ack is issued for it.
REQ-032 RAM contents are not cleared by rst.
REQ-033 mem_req is ignored on any edge where rst=1.

Verification
REQ-034 Word write/read:
- Stimulus: SW 32'hDEADBEEF to 0x10, then LW 0x10.
- Required: each ack 2 cycles after accept; read = DEADBEEF; mem_err=0.
REQ-035 Byte stores:
- Stimulus: SW 0 to 0x20; SB data 32'h5A5A5A5A to 0x21; SB data 32'hC3C3C3C3 to 0x23; LW 0x20.
- Required: read = C3005A00.
REQ-036 Errors:
- Stimulus: LW 0x22; SW to 0x0000_1000 (DEPTH 1024).
- Required: both mem_err=1, read data 0; word 0x1000>>2 does not exist; RAM unchanged.
REQ-037 MMIO:
- Stimulus: SW 32'h0000_00FF to LED_ADDR; SB data 32'h12121212 to LED_ADDR+3; two counter reads 3 cycles apart.
- Required: led = 120000FF; the counter reads differ by exactly 3.
REQ-038 Reset mid-access:
- Stimulus: SW 32'h11111111 to 0x0 after a prior SW 32'hAAAAAAAA to 0x0; rst=1 during ACCESS.
- Required: no ack; state IDLE; a subsequent LW 0x0 returns AAAAAAAA.
REQ-039 Held request and counter wrap:
- Stimulus: mem_req held high for 9 cycles; counter forced near wrap.
- Required: exactly 3 acks at 3-cycle spacing; counter reads FFFF_FFFF then 0000_0002 across the wrap.
